// File: rtl/me_batch_seq_if.sv
// me_batch_seq bus bundle: core req/ack transaction
// plus the show-ahead result stream.
interface me_batch_seq_if #(
  parameter int SAD_WIDTH = 16,
  parameter int CNT_WIDTH = 12,
  parameter int BLK_WIDTH = 2
);
  logic                 core_req;
  logic                 core_ack;
  logic [SAD_WIDTH-1:0] core_min_sad;
  logic [CNT_WIDTH-1:0] core_min_mvec;
  logic                 res_valid;
  logic                 res_ready;
  logic [SAD_WIDTH-1:0] res_sad;
  logic [CNT_WIDTH-1:0] res_mvec;
  logic [BLK_WIDTH-1:0] res_blk;

  modport master (
    output core_req,
    input  core_ack, core_min_sad, core_min_mvec,
    output res_valid, res_sad, res_mvec, res_blk,
    input  res_ready
  );

  modport slave (
    input  core_req,
    output core_ack, core_min_sad, core_min_mvec,
    input  res_valid, res_sad, res_mvec, res_blk,
    output res_ready
  );
endinterface

// File: rtl/me_batch_seq.sv
// me_batch_seq: runs the ME core over a batch of blocks,
// queues per-block results and tracks the batch best.
module me_batch_seq #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  parameter int NUM_BLOCKS   = 4,
  parameter int FIFO_DEPTH   = 4,
  localparam int SAD_WIDTH =
    $clog2(TB_LENGTH**2) + PE_OUT_WIDTH,
  localparam int CNT_WIDTH =
    $clog2((SW_LENGTH-TB_LENGTH+1)**2),
  localparam int BLK_WIDTH =
    (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 early_en,
  input  logic [SAD_WIDTH-1:0] sad_thresh,
  output logic                 busy,
  output logic                 done,
  output logic [BLK_WIDTH-1:0] blk_idx,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [CNT_WIDTH-1:0] best_mvec,
  output logic [BLK_WIDTH-1:0] best_blk,
  output logic                 early_exit,
  me_batch_seq_if.master       bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, WAIT_SPACE, REQ, RELEASE, FIN
  } state_t;

  state_t state, state_n;

  logic                 early_q;
  logic [SAD_WIDTH-1:0] thresh_q;
  logic                 exit_flag;
  logic                 push, pop, last_blk;
  logic [PTR_W:0]       count;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_nxt;

  logic [SAD_WIDTH-1:0] mem_sad  [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] mem_mvec [FIFO_DEPTH];
  logic [BLK_WIDTH-1:0] mem_blk  [FIFO_DEPTH];

  assign push     = (state == REQ) && bus.core_ack;
  assign pop      = bus.res_valid && bus.res_ready;
  assign rd_nxt   = rd_ptr + PTR_W'(1);
  assign last_blk = blk_idx == BLK_WIDTH'(NUM_BLOCKS-1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n      = state;
    bus.core_req = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        busy = 1'b1;
        if (count < (PTR_W+1)'(FIFO_DEPTH))
          state_n = REQ;
      end
      REQ: begin
        busy         = 1'b1;
        bus.core_req = 1'b1;
        if (bus.core_ack) state_n = RELEASE;
      end
      RELEASE: begin
        busy = 1'b1;
        if (!bus.core_ack)
          state_n = (exit_flag || last_blk) ? FIN
                                            : WAIT_SPACE;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Batch setup, best tracking and block stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      early_q    <= 1'b0;
      thresh_q   <= '0;
      exit_flag  <= 1'b0;
      blk_idx    <= '0;
      best_sad   <= '0;
      best_mvec  <= '0;
      best_blk   <= '0;
      early_exit <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        early_q    <= early_en;
        thresh_q   <= sad_thresh;
        exit_flag  <= 1'b0;
        blk_idx    <= '0;
        best_sad   <= '1;
        best_mvec  <= '0;
        best_blk   <= '0;
        early_exit <= 1'b0;
      end
      if (push) begin
        if (bus.core_min_sad < best_sad) begin
          best_sad  <= bus.core_min_sad;
          best_mvec <= bus.core_min_mvec;
          best_blk  <= blk_idx;
        end
        exit_flag <= early_q &&
                     (bus.core_min_sad <= thresh_q);
      end
      if (state == RELEASE && !bus.core_ack) begin
        if (exit_flag || last_blk)
          early_exit <= exit_flag;
        else
          blk_idx <= blk_idx + BLK_WIDTH'(1);
      end
    end
  end

  // Result storage (no reset needed, head regs gate it)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sad[wr_ptr]  <= bus.core_min_sad;
      mem_mvec[wr_ptr] <= bus.core_min_mvec;
      mem_blk[wr_ptr]  <= blk_idx;
    end
  end

  // Pointers, occupancy and registered show-ahead head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_sad   <= '0;
      bus.res_mvec  <= '0;
      bus.res_blk   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (pop) begin
        if (count > (PTR_W+1)'(1)) begin
          bus.res_sad  <= mem_sad[rd_nxt];
          bus.res_mvec <= mem_mvec[rd_nxt];
          bus.res_blk  <= mem_blk[rd_nxt];
        end else if (push) begin
          bus.res_sad  <= bus.core_min_sad;
          bus.res_mvec <= bus.core_min_mvec;
          bus.res_blk  <= blk_idx;
        end else begin
          bus.res_valid <= 1'b0;
        end
      end else if (count == '0 && push) begin
        bus.res_valid <= 1'b1;
        bus.res_sad   <= bus.core_min_sad;
        bus.res_mvec  <= bus.core_min_mvec;
        bus.res_blk   <= blk_idx;
      end
    end
  end

endmodule

// File: tb/tb_me_batch_seq.sv
// tb_me_batch_seq: random core model + batch-level
// reference model for me_batch_seq.
module tb_me_batch_seq;
  localparam int NB = 4;
  localparam int FD = 2;
  localparam int SW = 16;
  localparam int CW = 12;
  localparam int BW = 2;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic          early_en = 0;
  logic [SW-1:0] sad_thresh = '0;
  logic          busy, done, early_exit;
  logic [BW-1:0] blk_idx, best_blk;
  logic [SW-1:0] best_sad;
  logic [CW-1:0] best_mvec;

  me_batch_seq_if #(
    .SAD_WIDTH(SW), .CNT_WIDTH(CW), .BLK_WIDTH(BW)
  ) bus ();

  me_batch_seq #(
    .TB_LENGTH(16), .SW_LENGTH(64), .PE_OUT_WIDTH(8),
    .NUM_BLOCKS(NB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .early_en(early_en), .sad_thresh(sad_thresh),
    .busy(busy), .done(done), .blk_idx(blk_idx),
    .best_sad(best_sad), .best_mvec(best_mvec),
    .best_blk(best_blk), .early_exit(early_exit),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed = 0;

  logic [SW-1:0] sad_tab [NB];
  logic [CW-1:0] mvec_tab [NB];
  int  stall_blk = -1;
  int  ack_hold = 0;
  bit  poke = 0;
  int  viol = 0;
  bit  rr_rand = 0;

  int got_sad[$], got_mvec[$], got_blk[$], req_q[$];
  int done_cnt = 0;
  bit req_d = 0;

  int exp_sad[$], exp_mvec[$];
  logic [SW-1:0] exp_bsad;
  logic [CW-1:0] exp_bmvec;
  logic [BW-1:0] exp_bblk;
  bit exp_early;

  initial begin
    bus.core_ack = 0;
    bus.core_min_sad = '0;
    bus.core_min_mvec = '0;
    bus.res_ready = 1;
  end

  // core: random latency, holds ack until req drops
  always begin : core
    int l;
    bit ab;
    @(negedge clk);
    if (bus.core_req === 1'b1 && !bus.core_ack) begin
      l = (int'(blk_idx) == stall_blk) ? 300
                                      : $urandom_range(0, 3);
      ab = 0;
      for (int k = 0; k < l; k++) begin
        @(negedge clk);
        if (!bus.core_req) begin ab = 1; break; end
      end
      if (!ab) begin
        bus.core_min_sad = sad_tab[blk_idx];
        bus.core_min_mvec = mvec_tab[blk_idx];
        bus.core_ack = 1;
        for (int k = 0; k < 50 && bus.core_req; k++)
          @(negedge clk);
        for (int k = 0; k < ack_hold; k++) begin
          if (bus.core_req || !busy) viol++;
          if (poke) start = (k == 0);
          @(negedge clk);
        end
        if (poke) start = 0;
        bus.core_ack = 0;
        bus.core_min_sad = SW'($urandom);
        bus.core_min_mvec = CW'($urandom);
      end
    end
  end

  always @(negedge clk)
    if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));

  // observer: pops, request rises, done pulses
  always begin
    @(negedge clk);
    #2;
    if (bus.res_valid && bus.res_ready) begin
      got_sad.push_back(int'(bus.res_sad));
      got_mvec.push_back(int'(bus.res_mvec));
      got_blk.push_back(int'(bus.res_blk));
    end
    if (bus.core_req && !req_d) req_q.push_back(int'(blk_idx));
    req_d = bus.core_req;
    if (done) done_cnt++;
  end

  function automatic void ref_model(bit en, logic [SW-1:0] th);
    exp_sad.delete();
    exp_mvec.delete();
    exp_bsad = '1;
    exp_bmvec = '0;
    exp_bblk = '0;
    exp_early = 0;
    for (int b = 0; b < NB; b++) begin
      exp_sad.push_back(int'(sad_tab[b]));
      exp_mvec.push_back(int'(mvec_tab[b]));
      if (sad_tab[b] < exp_bsad) begin
        exp_bsad = sad_tab[b];
        exp_bmvec = mvec_tab[b];
        exp_bblk = BW'(b);
      end
      if (en && sad_tab[b] <= th) begin
        exp_early = 1;
        break;
      end
    end
  endfunction

  task automatic clear_obs();
    got_sad.delete(); got_mvec.delete(); got_blk.delete();
    req_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(output bit to);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    to = (done_cnt == 0);
    rr_rand = 0;
    bus.res_ready = 1;
    for (int j = 0; j < 20 && bus.res_valid; j++)
      @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_batch(input bit en, input logic [SW-1:0] th,
                           output bit to);
    clear_obs();
    @(negedge clk);
    early_en = en;
    sad_thresh = th;
    start = 1;
    @(negedge clk);
    start = 0;
    early_en = 1'($urandom);
    sad_thresh = SW'($urandom);
    wait_done(to);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({busy, done, bus.core_req, bus.res_valid, early_exit}
        !== 5'b0) begin
      failed++;
      $display("FAIL reset_ctl got=%b exp=00000",
        {busy, done, bus.core_req, bus.res_valid, early_exit});
    end
    tests_run++;
    if ({best_sad, best_mvec, best_blk, blk_idx, bus.res_sad}
        !== '0) begin
      failed++;
      $display("FAIL reset_data best_sad=%0d blk=%0d res_sad=%0d exp=0",
        best_sad, blk_idx, bus.res_sad);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    bit to;
    sad_tab = '{16'd50, 16'd20, 16'd20, 16'd90};
    mvec_tab = '{12'd7, 12'd3, 12'd9, 12'd1};
    run_batch(0, '0, to);
    ref_model(0, '0);
    tests_run++;
    if (to || done_cnt != 1) begin
      failed++;
      $display("FAIL basic_done got=%0d exp=1", done_cnt);
    end
    tests_run++;
    if (got_blk != '{0, 1, 2, 3} || got_sad != exp_sad ||
        got_mvec != exp_mvec) begin
      failed++;
      $display("FAIL basic_fifo got_n=%0d exp_n=4", got_sad.size());
    end
    tests_run++;
    if ({best_sad, best_mvec, best_blk} !==
        {16'd20, 12'd3, 2'd1}) begin
      failed++;
      $display("FAIL basic_best got=%0d/%0d/%0d exp=20/3/1",
        best_sad, best_mvec, best_blk);
    end
    tests_run++;
    if (early_exit !== 1'b0 || blk_idx !== 2'd3) begin
      failed++;
      $display("FAIL basic_end got=%b/%0d exp=0/3",
        early_exit, blk_idx);
    end
  endtask

  task automatic test_early();
    bit to;
    run_batch(1, 16'd25, to);
    ref_model(1, 16'd25);
    tests_run++;
    if (to || got_sad != '{50, 20} || got_blk != '{0, 1}) begin
      failed++;
      $display("FAIL early_fifo got_n=%0d exp_n=2", got_sad.size());
    end
    tests_run++;
    if (req_q != '{0, 1}) begin
      failed++;
      $display("FAIL early_reqs got=%0d exp=2", req_q.size());
    end
    tests_run++;
    if (early_exit !== 1'b1 || best_sad !== 16'd20 ||
        blk_idx !== 2'd1) begin
      failed++;
      $display("FAIL early_flag got=%b/%0d/%0d exp=1/20/1",
        early_exit, best_sad, blk_idx);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_obs();
    bus.res_ready = 0;
    @(negedge clk);
    early_en = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    #1;
    tests_run++;
    if (req_q.size() != 2 || bus.core_req !== 1'b0 ||
        busy !== 1'b1) begin
      failed++;
      $display("FAIL bp_stall reqs=%0d req=%b busy=%b exp=2/0/1",
        req_q.size(), bus.core_req, busy);
    end
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_blk !== 2'd0 ||
        bus.res_sad !== 16'd50) begin
      failed++;
      $display("FAIL bp_head got=%b/%0d/%0d exp=1/0/50",
        bus.res_valid, bus.res_blk, bus.res_sad);
    end
    bus.res_ready = 1;
    wait_done(to);
    ref_model(0, '0);
    tests_run++;
    if (to || got_blk != '{0, 1, 2, 3} || got_sad != exp_sad ||
        got_mvec != exp_mvec) begin
      failed++;
      $display("FAIL bp_resume got_n=%0d exp_n=4", got_sad.size());
    end
  endtask

  task automatic test_push_pop();
    bit to, seen;
    for (int b = 0; b < NB; b++) begin
      sad_tab[b] = SW'($urandom_range(100, 900));
      mvec_tab[b] = CW'($urandom);
    end
    clear_obs();
    bus.res_ready = 0;
    @(negedge clk);
    early_en = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid && bus.core_ack && bus.core_req) begin
        seen = 1;
        break;
      end
    end
    bus.res_ready = 1;
    @(negedge clk);
    bus.res_ready = 0;
    #1;
    tests_run++;
    if (!seen || bus.res_valid !== 1'b1 || bus.res_blk !== 2'd1 ||
        bus.res_sad !== sad_tab[1]) begin
      failed++;
      $display("FAIL pp_head got=%b/%0d/%0d exp=1/1/%0d",
        bus.res_valid, bus.res_blk, bus.res_sad, sad_tab[1]);
    end
    repeat (30) @(negedge clk);
    #1;
    tests_run++;
    if (req_q.size() != 3 || bus.core_req !== 1'b0) begin
      failed++;
      $display("FAIL pp_count reqs=%0d exp=3", req_q.size());
    end
    bus.res_ready = 1;
    wait_done(to);
    ref_model(0, '0);
    tests_run++;
    if (to || got_blk != '{0, 1, 2, 3} || got_sad != exp_sad) begin
      failed++;
      $display("FAIL pp_order got_n=%0d exp_n=4", got_sad.size());
    end
  endtask

  task automatic test_reset_mid();
    bit to, seen;
    clear_obs();
    stall_blk = 2;
    bus.res_ready = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.core_req && blk_idx == 2'd2) begin
        seen = 1;
        break;
      end
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    tests_run++;
    if (!seen || {bus.core_req, busy, bus.res_valid} !== 3'b0 ||
        best_sad !== '0) begin
      failed++;
      $display("FAIL rst_mid got=%b best=%0d exp=000/0",
        {bus.core_req, busy, bus.res_valid}, best_sad);
    end
    stall_blk = -1;
    for (int b = 0; b < NB; b++) begin
      sad_tab[b] = SW'($urandom_range(0, 60));
      mvec_tab[b] = CW'($urandom);
    end
    run_batch(0, '0, to);
    ref_model(0, '0);
    tests_run++;
    if (to || req_q.size() == 0 || req_q[0] != 0 ||
        got_sad != exp_sad || got_blk != '{0, 1, 2, 3}) begin
      failed++;
      $display("FAIL rst_rerun got_n=%0d exp_n=4", got_sad.size());
    end
  endtask

  task automatic test_ignored_start();
    bit to;
    for (int b = 0; b < NB; b++) begin
      sad_tab[b] = SW'($urandom_range(0, 60));
      mvec_tab[b] = CW'($urandom);
    end
    viol = 0;
    ack_hold = 3;
    poke = 1;
    run_batch(0, '0, to);
    poke = 0;
    ack_hold = 0;
    ref_model(0, '0);
    tests_run++;
    if (viol != 0) begin
      failed++;
      $display("FAIL ign_release got=%0d exp=0", viol);
    end
    tests_run++;
    if (to || done_cnt != 1 || got_sad != exp_sad ||
        got_blk != '{0, 1, 2, 3} || req_q.size() != 4) begin
      failed++;
      $display("FAIL ign_batch done=%0d got_n=%0d exp=1/4",
        done_cnt, got_sad.size());
    end
  endtask

  task automatic test_random();
    bit to, en;
    logic [SW-1:0] th;
    for (int it = 0; it < 8; it++) begin
      for (int b = 0; b < NB; b++) begin
        sad_tab[b] = SW'($urandom_range(0, 40));
        mvec_tab[b] = CW'($urandom);
      end
      en = 1'($urandom);
      th = SW'($urandom_range(0, 40));
      ack_hold = $urandom_range(0, 2);
      rr_rand = 1;
      run_batch(en, th, to);
      ref_model(en, th);
      tests_run++;
      if (to || got_sad != exp_sad || got_mvec != exp_mvec ||
          got_blk.size() != exp_sad.size()) begin
        failed++;
        $display("FAIL rnd%0d_fifo got_n=%0d exp_n=%0d",
          it, got_sad.size(), exp_sad.size());
      end
      tests_run++;
      if ({best_sad, best_mvec, best_blk, early_exit} !==
          {exp_bsad, exp_bmvec, exp_bblk, exp_early}) begin
        failed++;
        $display("FAIL rnd%0d_best got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b",
          it, best_sad, best_mvec, best_blk, early_exit,
          exp_bsad, exp_bmvec, exp_bblk, exp_early);
      end
      tests_run++;
      if (req_q.size() != exp_sad.size() || done_cnt != 1) begin
        failed++;
        $display("FAIL rnd%0d_reqs got=%0d/%0d exp=%0d/1",
          it, req_q.size(), done_cnt, exp_sad.size());
      end
    end
    ack_hold = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
